// File: rtl/serial_receive.sv
// serial_receive: 8N1 UART receiver assembling a 64-byte work frame into midstate/data2.
// Define SERIAL_RX_TIMEOUT_EN to drop partial frames after an inter-byte gap of timeout_bits.
module serial_receive #(
   parameter int comm_clk_frequency = 100_000_000,
   parameter int baud_rate = 115_200,
   parameter int timeout_bits = 100
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         RxD,
   output logic [255:0] midstate,
   output logic [255:0] data2,
   output logic         rx_done
);
   localparam int DIV = comm_clk_frequency / baud_rate;
   localparam int HALF = DIV / 2;
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t state, state_next;
   logic rx_meta, rx_s, rx_q;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift;
   logic [511:0] sr, sr_next;
   logic [5:0] byte_cnt;
   logic fall, tick, accept, timeout;

   assign fall = rx_q & ~rx_s;
   assign tick = cnt == (state == START ? HALF_M1 : DIV_M1);
   assign accept = state == STOP && tick && rx_s;
   assign sr_next = {shift, sr[511:8]};

   // synchroniser flops reset to the idle level so reset release never looks like a start edge
   always_ff @(posedge clk)
      if (!reset_n) {rx_meta, rx_s, rx_q} <= 3'b111;
      else {rx_meta, rx_s, rx_q} <= {RxD, rx_meta, rx_s};

   always_ff @(posedge clk)
      if (!reset_n) state <= IDLE;
      else state <= state_next;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = fall ? START : IDLE;
         START:   state_next = tick ? (rx_s ? IDLE : DATA) : START;
         DATA:    state_next = (tick && bit_idx == 3'd7) ? STOP : DATA;
         default: state_next = tick ? IDLE : STOP;
      endcase
   end

   always_ff @(posedge clk)
      if (!reset_n) begin
         cnt <= '0;
         bit_idx <= '0;
         shift <= '0;
         sr <= '0;
         byte_cnt <= '0;
         midstate <= '0;
         data2 <= '0;
         rx_done <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
         if (state == DATA && tick) begin
            shift <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (accept) begin
            sr <= sr_next;
            byte_cnt <= byte_cnt + 6'd1;
            if (byte_cnt == 6'd63) begin
               midstate <= sr_next[255:0];
               data2 <= sr_next[511:256];
               rx_done <= 1'b1;
            end
         end else if ((state == STOP && tick) || timeout) begin
            byte_cnt <= '0;
         end
      end

`ifdef SERIAL_RX_TIMEOUT_EN
   localparam int GAP = timeout_bits * DIV;
   localparam int GW = $clog2(GAP + 1);
   logic [GW-1:0] gap;
   assign timeout = gap == GW'(GAP);
   always_ff @(posedge clk)
      if (!reset_n || state != IDLE || byte_cnt == '0 || fall || timeout) gap <= '0;
      else gap <= gap + GW'(1);
`else
   assign timeout = timeout_bits < 0;
`endif
endmodule

// File: tb/tb_serial_receive.sv
// tb_serial_receive: randomized 8N1 stimulus checked against a byte-queue frame model.
module tb_serial_receive;
   localparam int DIV = 10;
   localparam int TO_BITS = 100;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic RxD = 1'b1;
   logic [255:0] midstate, data2;
   logic rx_done;

   serial_receive #(
      .comm_clk_frequency(1_000_000),
      .baud_rate(100_000),
      .timeout_bits(TO_BITS)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .RxD(RxD),
      .midstate(midstate),
      .data2(data2),
      .rx_done(rx_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0, done_cnt = 0;
   bit chk_on = 0;
   logic [7:0] q[$];
   bit pending = 0;
   int win_lo = 0, win_hi = 0;
   logic [255:0] exp_mid = '0, exp_d2 = '0, pend_mid = '0, pend_d2 = '0;

   task automatic check(string name, logic [255:0] act, logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // a frame completes when the 64th good byte since the last clear arrives
   function automatic void model_accept(logic [7:0] b, int st);
      q.push_back(b);
      if (q.size() == 64) begin
         for (int k = 0; k < 32; k++) begin
            pend_mid[8*k +: 8] = q[k];
            pend_d2[8*k +: 8] = q[32 + k];
         end
         pending = 1;
         win_lo = st + 9 * DIV;
         win_hi = st + 10 * DIV + 4;
         q.delete();
      end
   endfunction

   task automatic send_byte(logic [7:0] b, bit stop = 1);
      int st;
      st = cyc;
      if (stop) model_accept(b, st);
      else q.delete();
      RxD = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         tick(DIV);
      end
      RxD = stop;
      tick(DIV);
      if (!stop) begin
         RxD = 1'b1;
         tick(DIV);
      end
   endtask

   task automatic idle(int n);
      RxD = 1'b1;
      tick(n);
`ifdef SERIAL_RX_TIMEOUT_EN
      if (n > TO_BITS * DIV + DIV) q.delete();
`endif
   endtask

   task automatic do_reset(int n);
      RxD = 1'b1;
      reset_n = 1'b0;
      tick(1);
      q.delete();
      pending = 0;
      exp_mid = '0;
      exp_d2 = '0;
      tick(n - 1);
      reset_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         n_chk++;
         if (rx_done === 1'b1) begin
            done_cnt++;
            if (pending && cyc >= win_lo && cyc <= win_hi) begin
               exp_mid = pend_mid;
               exp_d2 = pend_d2;
               pending = 0;
            end else begin
               n_fail++;
               $display("FAIL rx_done_unexpected: rx_done=1 at cycle %0d, required 0", cyc);
            end
         end else if (rx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_done_known: rx_done=%b at cycle %0d, required 0/1", rx_done, cyc);
         end else if (pending && cyc > win_hi) begin
            n_fail++;
            $display("FAIL rx_done_missing: rx_done=0 through cycle %0d, required a pulse", cyc);
            pending = 0;
         end
         check("midstate_held", midstate, exp_mid);
         check("data2_held", data2, exp_d2);
      end
   end

   initial begin
      int d0;
      logic [7:0] first, b;
      reset_n = 1'b0;
      RxD = 1'b1;
      tick(5);
      check("reset_midstate", midstate, '0);
      check("reset_data2", data2, '0);
      check("reset_rx_done", {255'd0, rx_done}, '0);
      chk_on = 1;
      reset_n = 1'b1;
      tick(3);

      d0 = done_cnt;
      for (int i = 0; i < 64; i++) send_byte(8'(i));
      tick(10);
      check("frame1_pulses", 256'(done_cnt - d0), 256'd1);
      check("frame1_mid_lo", {248'd0, midstate[7:0]}, 256'h00);
      check("frame1_mid_hi", {248'd0, midstate[255:248]}, 256'h1F);
      check("frame1_d2_lo", {248'd0, data2[7:0]}, 256'h20);
      check("frame1_d2_hi", {248'd0, data2[255:248]}, 256'h3F);

      d0 = done_cnt;
      for (int i = 0; i < 64; i++) send_byte(8'hAA);
      for (int i = 0; i < 64; i++) send_byte(8'h55);
      tick(10);
      check("b2b_pulses", 256'(done_cnt - d0), 256'd2);
      check("b2b_mid", midstate, {32{8'h55}});
      check("b2b_d2", data2, {32{8'h55}});

      d0 = done_cnt;
      RxD = 1'b0;
      tick(3);
      RxD = 1'b1;
      tick(20);
      for (int i = 0; i < 10; i++) send_byte(8'($urandom));
      send_byte(8'($urandom), 0);
      RxD = 1'b0;
      tick(150);
      q.delete();
      RxD = 1'b1;
      tick(2 * DIV);
      first = 8'($urandom);
      send_byte(first);
      for (int i = 1; i < 64; i++) send_byte(8'($urandom));
      tick(10);
      check("ferr_pulses", 256'(done_cnt - d0), 256'd1);
      check("ferr_align", {248'd0, midstate[7:0]}, {248'd0, first});

      for (int i = 0; i < 30; i++) send_byte(8'($urandom));
      do_reset(5);
      tick(3);
      d0 = done_cnt;
      first = 8'($urandom);
      send_byte(first);
      for (int i = 1; i < 64; i++) send_byte(8'($urandom));
      tick(10);
      check("rst_pulses", 256'(done_cnt - d0), 256'd1);
      check("rst_align", {248'd0, midstate[7:0]}, {248'd0, first});

      b = 8'($urandom);
      send_byte(b);
      for (int i = 1; i < 10; i++) send_byte(8'($urandom));
      idle(1100);
      d0 = done_cnt;
      first = 8'($urandom);
      send_byte(first);
      for (int i = 1; i < 54; i++) send_byte(8'($urandom));
      tick(5);
`ifdef SERIAL_RX_TIMEOUT_EN
      check("gap_54_pulses", 256'(done_cnt - d0), 256'd0);
`else
      check("gap_54_pulses", 256'(done_cnt - d0), 256'd1);
`endif
      for (int i = 54; i < 64; i++) send_byte(8'($urandom));
      tick(10);
      check("gap_64_pulses", 256'(done_cnt - d0), 256'd1);
`ifdef SERIAL_RX_TIMEOUT_EN
      check("gap_align", {248'd0, midstate[7:0]}, {248'd0, first});
`else
      check("gap_align", {248'd0, midstate[7:0]}, {248'd0, b});
`endif

      for (int i = 0; i < 60; i++) begin
         send_byte(8'($urandom), $urandom_range(15) != 0);
         if ($urandom_range(3) == 0) idle($urandom_range(30, 1));
      end
      tick(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
